pf_clk_div_align_ctrl: RTL and testbench

PF_CLK_DIV_ALIGN_CTRL -- requirements
Module: pf_clk_div_align_ctrl

---
 rtl/pf_clk_div_align_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pf_clk_div_align_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_clk_div_align_ctrl.sv
// Training controller that aligns a divided fabric clock to the serial data.
// It steps through bit-slip positions and delay-line taps until the
// deserialized word matches the training pattern for COMPARE_WORDS
// consecutive cycles, or reports failure when the search space is exhausted.
module pf_clk_div_align_ctrl #(
    parameter int unsigned             DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0]   TRAIN_PATTERN = DATA_WIDTH'(8'hB8),
    parameter int unsigned             DIVIDE        = 4,
    parameter int unsigned             MAX_TAPS      = 127,
    parameter int unsigned             SETTLE_CYCLES = 16,
    parameter int unsigned             COMPARE_WORDS = 8,
    parameter int unsigned             RST_CYCLES    = 4
) (
    input  logic                  SCLK,
    input  logic                  RESETN,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  DELAY_LINE_OUT_OF_RANGE,
    output logic                  CDD_RST_N,
    output logic                  DELAY_LINE_LOAD,
    output logic                  DELAY_LINE_MOVE,
    output logic                  DELAY_LINE_DIR,
    output logic                  BIT_SLIP,
    output logic [7:0]            TAP_CNT,
    output logic [2:0]            SLIP_CNT,
    output logic                  DONE,
    output logic                  FAIL,
    output logic                  BUSY
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TAP_W  = 8;
    localparam int unsigned SLIP_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CDD_RST = 4'd1,
        ST_LOAD    = 4'd2,
        ST_SETTLE  = 4'd3,
        ST_CHECK   = 4'd4,
        ST_SLIP    = 4'd5,
        ST_MOVE    = 4'd6,
        ST_DONE    = 4'd7,
        ST_FAIL    = 4'd8
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAP_W-1:0]    tap_cnt_q, tap_cnt_d;
    logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
    logic                cdd_rst_n_q, cdd_rst_n_d;
    logic                load_q, load_d;
    logic                move_q, move_d;
    logic                bit_slip_q, bit_slip_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic                busy_q, busy_d;
    logic                dir_q;

    logic                word_match;
    logic                idle_like_q;
    logic                idle_like_d;

    assign word_match  = (RX_DATA == TRAIN_PATTERN);
    assign idle_like_q = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign idle_like_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL);

    // State and shared phase counter register
    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt restarts at 0 on every state change.
    // MOVE spends one cycle deciding (end-stop sampled here) and, if stepping,
    // a second cycle carrying the DELAY_LINE_MOVE pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (START) state_d = ST_CDD_RST;
            end
            ST_CDD_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (word_match) begin
                    if (cnt_q == CNT_W'(COMPARE_WORDS - 1)) state_d = ST_DONE;
                end else if (slip_cnt_q < SLIP_W'(DIVIDE - 1)) begin
                    state_d = ST_SLIP;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_SLIP: begin
                state_d = ST_SETTLE;
            end
            ST_MOVE: begin
                if (cnt_q == '0) begin
                    if ((tap_cnt_q == TAP_W'(MAX_TAPS)) || DELAY_LINE_OUT_OF_RANGE) begin
                        state_d = ST_FAIL;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == state_q) && !idle_like_q) cnt_d = cnt_q + CNT_W'(1);
    end

    // Output/counter next values, aligned with the state being entered
    always_comb begin
        cdd_rst_n_d = (state_d != ST_CDD_RST);
        load_d      = (state_d == ST_LOAD);
        bit_slip_d  = (state_d == ST_SLIP);
        move_d      = (state_q == ST_MOVE) && (state_d == ST_MOVE);
        done_d      = (state_d == ST_DONE);
        fail_d      = (state_d == ST_FAIL);
        busy_d      = !idle_like_d;
        tap_cnt_d   = tap_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        if (idle_like_q && (state_d == ST_CDD_RST)) begin
            tap_cnt_d  = '0;
            slip_cnt_d = '0;
        end
        if (bit_slip_d) slip_cnt_d = slip_cnt_q + SLIP_W'(1);
        if (move_d) begin
            tap_cnt_d  = tap_cnt_q + TAP_W'(1);
            slip_cnt_d = '0;
        end
    end

    // Output registers
    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            cdd_rst_n_q <= 1'b0;
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            bit_slip_q  <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            dir_q       <= 1'b1;
            tap_cnt_q   <= '0;
            slip_cnt_q  <= '0;
        end else begin
            cdd_rst_n_q <= cdd_rst_n_d;
            load_q      <= load_d;
            move_q      <= move_d;
            bit_slip_q  <= bit_slip_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            dir_q       <= 1'b1;
            tap_cnt_q   <= tap_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
        end
    end

    assign CDD_RST_N       = cdd_rst_n_q;
    assign DELAY_LINE_LOAD = load_q;
    assign DELAY_LINE_MOVE = move_q;
    assign DELAY_LINE_DIR  = dir_q;
    assign BIT_SLIP        = bit_slip_q;
    assign TAP_CNT         = tap_cnt_q;
    assign SLIP_CNT        = slip_cnt_q;
    assign DONE            = done_q;
    assign FAIL            = fail_q;
    assign BUSY            = busy_q;

endmodule

// File: tb/tb_pf_clk_div_align_ctrl.sv
// Bench for pf_clk_div_align_ctrl: two instances (default and MAX_TAPS=3),
// a channel model per instance that produces RX_DATA from the observed
// load/move/slip pulses, and a scoreboard monitor that checks each run result.
module tb_pf_clk_div_align_ctrl;

    typedef struct {
        bit done;
        int tap;
        int slip;
        int n_move;
        int n_slip;
        int lat;      // cycles from CDD_RST_N fall to result, -1 = unchecked
        int min_gap;  // minimum spacing of BIT_SLIP pulses, 0 = unchecked
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_w, oor_w, cdd_w, load_w, move_w, dir_w, bslip_w;
    logic [1:0] done_w, fail_w, busy_w;
    logic [7:0] rx_w   [2];
    logic [7:0] tap_w  [2];
    logic [2:0] slip_w [2];

    // channel model configuration: 0 always match, 1 match at target, 2 never
    int mode [2], t_tap [2], t_slip [2], oor_tap [2];
    bit oor_en [2], bad [2];
    int ch_tap [2], ch_slip [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$], q1[$];

    pf_clk_div_align_ctrl dut0 (
        .SCLK(clk), .RESETN(rst_n), .START(start_w[0]), .RX_DATA(rx_w[0]),
        .DELAY_LINE_OUT_OF_RANGE(oor_w[0]), .CDD_RST_N(cdd_w[0]),
        .DELAY_LINE_LOAD(load_w[0]), .DELAY_LINE_MOVE(move_w[0]),
        .DELAY_LINE_DIR(dir_w[0]), .BIT_SLIP(bslip_w[0]), .TAP_CNT(tap_w[0]),
        .SLIP_CNT(slip_w[0]), .DONE(done_w[0]), .FAIL(fail_w[0]), .BUSY(busy_w[0])
    );

    pf_clk_div_align_ctrl #(.MAX_TAPS(3)) dut1 (
        .SCLK(clk), .RESETN(rst_n), .START(start_w[1]), .RX_DATA(rx_w[1]),
        .DELAY_LINE_OUT_OF_RANGE(oor_w[1]), .CDD_RST_N(cdd_w[1]),
        .DELAY_LINE_LOAD(load_w[1]), .DELAY_LINE_MOVE(move_w[1]),
        .DELAY_LINE_DIR(dir_w[1]), .BIT_SLIP(bslip_w[1]), .TAP_CNT(tap_w[1]),
        .SLIP_CNT(slip_w[1]), .DONE(done_w[1]), .FAIL(fail_w[1]), .BUSY(busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Physical channel: tap/slip position follows the pulses the controller sends
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!cdd_w[u]) begin
                ch_tap[u]  <= 0;
                ch_slip[u] <= 0;
            end else if (load_w[u]) begin
                ch_tap[u] <= 0;
            end else if (move_w[u]) begin
                ch_tap[u]  <= ch_tap[u] + 1;
                ch_slip[u] <= 0;
            end else if (bslip_w[u]) begin
                ch_slip[u] <= ch_slip[u] + 1;
            end
        end
    end

    // Deserialized word and end-stop flag presented by the channel
    always_comb begin
        for (int u = 0; u < 2; u++) begin
            case (mode[u])
                0:       rx_w[u] = bad[u] ? 8'h00 : 8'hB8;
                1:       rx_w[u] = (ch_tap[u] == t_tap[u] && ch_slip[u] == t_slip[u]) ? 8'hB8 : 8'h47;
                default: rx_w[u] = 8'hB9;
            endcase
            oor_w[u] = oor_en[u] && (ch_tap[u] >= oor_tap[u]);
        end
    end

    // Scoreboard monitor
    int cyc = 0;
    int t0 [2], n_move [2], n_slip [2], n_load [2], n_rlow [2], last_slip [2], min_gap [2];
    bit viol [2], prev_cdd [2], prev_res [2], prev_pulse [2];

    task automatic check_result(input int u);
        exp_t e;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            cmp($sformatf("u%0d_unexpected_result", u), 1, 0);
            return;
        end
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        cmp($sformatf("u%0d_done", u), int'(done_w[u]), int'(e.done));
        cmp($sformatf("u%0d_fail", u), int'(fail_w[u]), int'(!e.done));
        cmp($sformatf("u%0d_tap_cnt", u), int'(tap_w[u]), e.tap);
        cmp($sformatf("u%0d_slip_cnt", u), int'(slip_w[u]), e.slip);
        cmp($sformatf("u%0d_move_pulses", u), n_move[u], e.n_move);
        cmp($sformatf("u%0d_slip_pulses", u), n_slip[u], e.n_slip);
        cmp($sformatf("u%0d_load_pulses", u), n_load[u], 1);
        cmp($sformatf("u%0d_cdd_rst_low_cycles", u), n_rlow[u], 4);
        cmp($sformatf("u%0d_pulse_rule_violation", u), int'(viol[u]), 0);
        if (e.lat >= 0) cmp($sformatf("u%0d_latency", u), cyc - t0[u], e.lat);
        if (e.min_gap > 0) cmp($sformatf("u%0d_slip_gap_ok", u), int'(min_gap[u] >= e.min_gap), 1);
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                n_move[u] = 0; n_slip[u] = 0; n_load[u] = 0; n_rlow[u] = 0;
                viol[u] = 0; prev_cdd[u] = 0; prev_res[u] = 0; prev_pulse[u] = 0;
            end else begin
                if (prev_cdd[u] && !cdd_w[u]) begin
                    t0[u] = cyc; n_move[u] = 0; n_slip[u] = 0; n_load[u] = 0;
                    n_rlow[u] = 0; viol[u] = 0; last_slip[u] = -1; min_gap[u] = 1000000;
                end
                if (!cdd_w[u]) n_rlow[u]++;
                if (load_w[u]) n_load[u]++;
                if (move_w[u]) n_move[u]++;
                if (bslip_w[u]) begin
                    n_slip[u]++;
                    if (last_slip[u] >= 0 && (cyc - last_slip[u]) < min_gap[u]) min_gap[u] = cyc - last_slip[u];
                    last_slip[u] = cyc;
                end
                if ((int'(load_w[u]) + int'(move_w[u]) + int'(bslip_w[u])) > 1) viol[u] = 1;
                if ((load_w[u] | move_w[u] | bslip_w[u]) && prev_pulse[u]) viol[u] = 1;
                if (done_w[u] && fail_w[u]) viol[u] = 1;
                if ((done_w[u] | fail_w[u]) && !prev_res[u]) check_result(u);
                prev_cdd[u]   = cdd_w[u];
                prev_res[u]   = done_w[u] | fail_w[u];
                prev_pulse[u] = load_w[u] | move_w[u] | bslip_w[u];
            end
        end
    end

    function automatic exp_t mk(input bit done, input int tap, input int slip, input int nm,
                                input int ns, input int lat, input int gap);
        exp_t e;
        e.done = done; e.tap = tap; e.slip = slip; e.n_move = nm;
        e.n_slip = ns; e.lat = lat; e.min_gap = gap;
        return e;
    endfunction

    task automatic push(input int u, input exp_t e);
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic config_chan(input int u, input int m, input int tt, input int ts,
                               input bit oe, input int ot);
        mode[u] = m; t_tap[u] = tt; t_slip[u] = ts; oor_en[u] = oe; oor_tap[u] = ot; bad[u] = 0;
    endtask

    task automatic pulse_start(input int u);
        @(negedge clk);
        start_w[u] = 1'b1;
        @(negedge clk);
        start_w[u] = 1'b0;
    endtask

    task automatic wait_result(input int u);
        int n;
        n = 0;
        while (!(done_w[u] | fail_w[u]) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        cmp($sformatf("u%0d_run_completes", u), int'(n < 4000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input int u, input int m, input int tt, input int ts,
                       input bit oe, input int ot, input exp_t e);
        config_chan(u, m, tt, ts, oe, ot);
        push(u, e);
        pulse_start(u);
        wait_result(u);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_w = 2'b00;
        for (int u = 0; u < 2; u++) config_chan(u, 2, 0, 0, 1'b0, 0);
        repeat (3) @(negedge clk);
        cmp("reset_cdd_rst_n", int'(cdd_w[0]), 0);
        cmp("reset_dir", int'(dir_w[0]), 1);
        cmp("reset_flags", int'({done_w[0], fail_w[0], busy_w[0]}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("cdd_rst_n_high_after_reset", int'(cdd_w[0]), 1);
        cmp("idle_flags", int'({done_w[0], fail_w[0], busy_w[0]}), 0);

        // Aligned immediately: 4 + 1 + 16 + 8 cycles
        run(0, 0, 0, 0, 1'b0, 0, mk(1'b1, 0, 0, 0, 0, 29, 0));
        // Aligned after three slips; each slip round is settle + one check + slip
        run(0, 1, 0, 3, 1'b0, 0, mk(1'b1, 0, 3, 0, 3, 83, 17));
        // Aligned at tap 5, slip 2: three slips per exhausted tap, then two more
        run(0, 1, 5, 2, 1'b0, 0, mk(1'b1, 5, 2, 5, 17, -1, 0));
        // Never matches on the MAX_TAPS=3 instance: taps 0..3 fully slipped
        run(1, 2, 0, 0, 1'b0, 0, mk(1'b0, 3, 3, 3, 12, -1, 0));
        // End-stop flag raised once tap 2 is reached
        run(0, 2, 0, 0, 1'b1, 2, mk(1'b0, 2, 3, 2, 9, -1, 0));

        // Eighth word corrupted, plus START pulses while busy
        config_chan(0, 0, 0, 0, 1'b0, 0);
        push(0, mk(1'b1, 0, 1, 0, 1, 54, 0));
        pulse_start(0);
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            start_w[0] = (k == 10 || k == 22);
        end
        bad[0] = 1'b1;
        @(negedge clk);
        bad[0] = 1'b0;
        wait_result(0);

        // Reset during SETTLE at tap 1 abandons the run
        config_chan(0, 1, 1, 1, 1'b0, 0);
        pulse_start(0);
        repeat (85) @(negedge clk);
        cmp("busy_mid_run", int'(busy_w[0]), 1);
        cmp("tap_before_reset", int'(tap_w[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        cmp("midrun_reset_cdd_rst_n", int'(cdd_w[0]), 0);
        cmp("midrun_reset_pulses", int'({load_w[0], move_w[0], bslip_w[0]}), 0);
        cmp("midrun_reset_dir", int'(dir_w[0]), 1);
        cmp("midrun_reset_tap", int'(tap_w[0]), 0);
        cmp("midrun_reset_slip", int'(slip_w[0]), 0);
        cmp("midrun_reset_flags", int'({done_w[0], fail_w[0], busy_w[0]}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("cdd_rst_n_high_after_midrun_reset", int'(cdd_w[0]), 1);
        // Retrain from tap 0
        run(0, 0, 0, 0, 1'b0, 0, mk(1'b1, 0, 0, 0, 0, 29, 0));

        repeat (5) @(negedge clk);
        cmp("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
